// File: rtl/binary_aggregator_pkg.sv
// Shared definitions for the binary aggregator slot manager: width helpers,
// the {tag, payload} layout of aggregator data, and the per-slot state encoding.
package binary_aggregator_pkg;

    typedef enum logic [1:0] {
        SLOT_FREE = 2'd0,
        SLOT_OCC  = 2'd1,
        SLOT_COOL = 2'd2
    } slot_state_e;

    // Number of bits needed to encode values 0..value-1.
    function automatic int log2_ceil(input int value);
        int bits;
        bits = 0;
        for (int b = 0; b < 31; b++) begin
            if ((1 << b) < value) begin
                bits = b + 1;
            end
        end
        return bits;
    endfunction

    // Index width with a floor of one bit so single-value fields stay legal.
    function automatic int idx_width(input int cnt);
        return (log2_ceil(cnt) < 1) ? 1 : log2_ceil(cnt);
    endfunction

    // The slot tag occupies the top IDX_W bits of the aggregator data word.
    function automatic int tag_msb(input int data_width, input int idx_w);
        return data_width + idx_w - 1;
    endfunction

endpackage

// File: rtl/aggregator_slot.sv
// One candidate slot: occupancy, post-retire cooldown, key and payload,
// with a saturating aging step toward the winning direction.
module aggregator_slot
    import binary_aggregator_pkg::*;
#(
    parameter int KEY_WIDTH     = 6,
    parameter int DATA_WIDTH    = 16,
    parameter int AGG_LATENCY   = 0,
    parameter int KEY_WINS_HIGH = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_alloc,
    input  logic [KEY_WIDTH-1:0]  i_key,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_retire,
    input  logic                  i_age_tick,
    output logic                  o_occ,
    output logic                  o_free,
    output logic [KEY_WIDTH-1:0]  o_key,
    output logic [DATA_WIDTH-1:0] o_data
);

    localparam int                   COOL_W    = idx_width(AGG_LATENCY + 2);
    localparam logic [COOL_W-1:0]    COOL_INIT = COOL_W'(AGG_LATENCY + 1);
    localparam logic [KEY_WIDTH-1:0] KEY_LIMIT = (KEY_WINS_HIGH != 0) ? {KEY_WIDTH{1'b1}}
                                                                      : {KEY_WIDTH{1'b0}};

    logic                  r_occ;
    logic [COOL_W-1:0]     r_cool;
    logic [KEY_WIDTH-1:0]  r_key;
    logic [DATA_WIDTH-1:0] r_data;

    slot_state_e           w_state;
    logic [KEY_WIDTH-1:0]  w_key_aged;

    always_comb begin
        w_state = SLOT_FREE;
        if (r_cool != '0) begin
            w_state = SLOT_COOL;
        end else if (r_occ) begin
            w_state = SLOT_OCC;
        end
    end

    always_comb begin
        w_key_aged = r_key;
        if (r_key != KEY_LIMIT) begin
            w_key_aged = (KEY_WINS_HIGH != 0) ? (r_key + 1'b1) : (r_key - 1'b1);
        end
    end

    // Retire and alloc are exclusive: retire needs an occupied slot, alloc a free one.
    // The cooldown covers every winner still in aggregator flight for this slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ  <= 1'b0;
            r_cool <= '0;
            r_key  <= '0;
            r_data <= '0;
        end else if (i_retire) begin
            r_occ  <= 1'b0;
            r_cool <= COOL_INIT;
        end else if (i_alloc) begin
            r_occ  <= 1'b1;
            r_key  <= i_key;
            r_data <= i_data;
        end else begin
            if (r_cool != '0) begin
                r_cool <= r_cool - 1'b1;
            end
            if (r_occ && i_age_tick) begin
                r_key <= w_key_aged;
            end
        end
    end

    assign o_occ  = (w_state == SLOT_OCC);
    assign o_free = (w_state == SLOT_FREE);
    assign o_key  = r_key;
    assign o_data = r_data;

endmodule

// File: rtl/binary_aggregator_slot_manager.sv
// Parks pushed entries in free slots, presents them to the binary aggregator,
// forwards qualified winners on the pop port and retires the popped slot.
module binary_aggregator_slot_manager
    import binary_aggregator_pkg::*;
#(
    parameter  int CANDIDATE_CNT = 5,
    parameter  int KEY_WIDTH     = 6,
    parameter  int DATA_WIDTH    = 16,
    parameter  int AGG_LATENCY   = 0,
    parameter  int AGE_PERIOD    = 16,
    parameter  int KEY_WINS_HIGH = 1,
    localparam int IDX_W         = idx_width(CANDIDATE_CNT),
    localparam int AGG_DW        = DATA_WIDTH + IDX_W
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     push_vld,
    output logic                                     push_rdy,
    input  logic [KEY_WIDTH-1:0]                     push_key,
    input  logic [DATA_WIDTH-1:0]                    push_data,
    output logic [CANDIDATE_CNT-1:0]                 candidate_vld,
    output logic [CANDIDATE_CNT-1:0][KEY_WIDTH-1:0]  candidate_key,
    output logic [CANDIDATE_CNT-1:0][AGG_DW-1:0]     candidate_data,
    input  logic                                     winner_vld,
    input  logic [KEY_WIDTH-1:0]                     winner_key,
    input  logic [AGG_DW-1:0]                        winner_data,
    output logic                                     pop_vld,
    input  logic                                     pop_rdy,
    output logic [KEY_WIDTH-1:0]                     pop_key,
    output logic [DATA_WIDTH-1:0]                    pop_data
);

    localparam int TAG_MSB = tag_msb(DATA_WIDTH, IDX_W);

    logic [CANDIDATE_CNT-1:0] w_occ;
    logic [CANDIDATE_CNT-1:0] w_free;
    logic [CANDIDATE_CNT-1:0] w_alloc;
    logic [CANDIDATE_CNT-1:0] w_retire;
    logic [CANDIDATE_CNT-1:0] w_tag_hit;
    logic [IDX_W-1:0]         w_tag;
    logic                     w_age_tick;
    logic                     w_pop_fire;

    // Lowest set bit of the free mask selects the slot for a new entry.
    assign push_rdy = |w_free;
    assign w_alloc  = push_vld ? (w_free & (~w_free + 1'b1)) : '0;

    // A tag beyond CANDIDATE_CNT matches no slot and therefore never qualifies.
    assign w_tag      = winner_data[TAG_MSB -: IDX_W];
    assign pop_vld    = winner_vld & (|(w_tag_hit & w_occ));
    assign w_pop_fire = pop_vld & pop_rdy;
    assign pop_key    = winner_key;
    assign pop_data   = winner_data[DATA_WIDTH-1:0];

    assign candidate_vld = w_occ;

    generate
        for (genvar gi = 0; gi < CANDIDATE_CNT; gi++) begin : g_slot
            logic [KEY_WIDTH-1:0]  w_slot_key;
            logic [DATA_WIDTH-1:0] w_slot_data;

            assign w_tag_hit[gi] = (w_tag == IDX_W'(gi));
            assign w_retire[gi]  = w_pop_fire & w_tag_hit[gi];

            aggregator_slot #(
                .KEY_WIDTH     (KEY_WIDTH),
                .DATA_WIDTH    (DATA_WIDTH),
                .AGG_LATENCY   (AGG_LATENCY),
                .KEY_WINS_HIGH (KEY_WINS_HIGH)
            ) u_slot (
                .clk        (clk),
                .rst_n      (rst_n),
                .i_alloc    (w_alloc[gi]),
                .i_key      (push_key),
                .i_data     (push_data),
                .i_retire   (w_retire[gi]),
                .i_age_tick (w_age_tick),
                .o_occ      (w_occ[gi]),
                .o_free     (w_free[gi]),
                .o_key      (w_slot_key),
                .o_data     (w_slot_data)
            );

            assign candidate_key[gi]  = w_slot_key;
            assign candidate_data[gi] = {IDX_W'(gi), w_slot_data};
        end
    endgenerate

    generate
        if (AGE_PERIOD > 0) begin : g_age
            localparam int               AGE_W    = idx_width(AGE_PERIOD);
            localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(AGE_PERIOD - 1);

            logic [AGE_W-1:0] r_age_cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_age_cnt <= '0;
                end else if (r_age_cnt == AGE_LAST) begin
                    r_age_cnt <= '0;
                end else begin
                    r_age_cnt <= r_age_cnt + 1'b1;
                end
            end

            assign w_age_tick = (r_age_cnt == AGE_LAST);
        end else begin : g_no_age
            assign w_age_tick = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_binary_aggregator_slot_manager.sv
// Self-checking bench: a slot-level reference model drives an ideal aggregator
// with latency, and every cycle the DUT outputs are compared against the model.
module tb_binary_aggregator_slot_manager;

    localparam int N  = 5;
    localparam int KW = 6;
    localparam int DW = 16;
    localparam int L  = 2;
    localparam int P  = 4;
    localparam int IW = 3;

    typedef struct packed {
        logic           vld;
        logic [KW-1:0]  key;
        logic [DW+IW-1:0] data;
    } win_t;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b1;
    logic                    push_vld = 1'b0;
    logic                    push_rdy;
    logic [KW-1:0]           push_key = '0;
    logic [DW-1:0]           push_data = '0;
    logic [N-1:0]            candidate_vld;
    logic [N-1:0][KW-1:0]    candidate_key;
    logic [N-1:0][DW+IW-1:0] candidate_data;
    logic                    winner_vld = 1'b0;
    logic [KW-1:0]           winner_key = '0;
    logic [DW+IW-1:0]        winner_data = '0;
    logic                    pop_vld;
    logic                    pop_rdy = 1'b0;
    logic [KW-1:0]           pop_key;
    logic [DW-1:0]           pop_data;

    always #5 clk = ~clk;

    binary_aggregator_slot_manager #(
        .CANDIDATE_CNT (N),
        .KEY_WIDTH     (KW),
        .DATA_WIDTH    (DW),
        .AGG_LATENCY   (L),
        .AGE_PERIOD    (P),
        .KEY_WINS_HIGH (1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .push_vld       (push_vld),
        .push_rdy       (push_rdy),
        .push_key       (push_key),
        .push_data      (push_data),
        .candidate_vld  (candidate_vld),
        .candidate_key  (candidate_key),
        .candidate_data (candidate_data),
        .winner_vld     (winner_vld),
        .winner_key     (winner_key),
        .winner_data    (winner_data),
        .pop_vld        (pop_vld),
        .pop_rdy        (pop_rdy),
        .pop_key        (pop_key),
        .pop_data       (pop_data)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: slot contents plus the cycle at which a retired slot is reusable.
    bit            m_occ [N];
    logic [KW-1:0] m_key [N];
    logic [DW-1:0] m_data[N];
    int            m_free_at[N];
    int            cyc;
    win_t          agg_q[$];
    bit            bad_tag_inj = 1'b0;
    logic          pv_log[$];
    logic [DW+IW-1:0] pop_log[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_occ[i] = 1'b0;
            m_key[i] = '0;
            m_data[i] = '0;
            m_free_at[i] = 0;
        end
        cyc = 0;
        agg_q.delete();
        for (int i = 0; i < L; i++) agg_q.push_back('0);
    endtask

    task automatic do_reset();
        push_vld = 1'b0;
        pop_rdy  = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // One clock cycle: drive inputs, compare outputs, clock, advance the model.
    task automatic step(input bit pv, input logic [KW-1:0] pk, input logic [DW-1:0] pd, input bit pr);
        win_t best;
        win_t w;
        int tag;
        int fslot;
        bit rdy_e;
        bit pop_e;
        logic [N-1:0] cv_e;

        best = '0;
        for (int i = 0; i < N; i++) begin
            if (m_occ[i] && (!best.vld || m_key[i] > best.key)) begin
                best.vld  = 1'b1;
                best.key  = m_key[i];
                best.data = {IW'(i), m_data[i]};
            end
        end
        agg_q.push_back(best);
        w = agg_q.pop_front();
        if (bad_tag_inj) begin
            w.vld = 1'b1;
            w.data[DW+IW-1 -: IW] = 3'd6;
        end

        winner_vld  = w.vld;
        winner_key  = w.key;
        winner_data = w.data;
        push_vld    = pv;
        push_key    = pk;
        push_data   = pd;
        pop_rdy     = pr;
        #1;

        fslot = -1;
        for (int i = 0; i < N; i++) begin
            if (fslot < 0 && !m_occ[i] && cyc >= m_free_at[i]) fslot = i;
        end
        rdy_e = (fslot >= 0);
        tag   = int'(w.data[DW+IW-1 -: IW]);
        pop_e = 1'b0;
        if (w.vld && tag < N) begin
            if (m_occ[tag] && cyc >= m_free_at[tag]) pop_e = 1'b1;
        end
        for (int i = 0; i < N; i++) cv_e[i] = m_occ[i];

        chk("push_rdy", 64'(push_rdy), 64'(rdy_e));
        chk("pop_vld", 64'(pop_vld), 64'(pop_e));
        chk("candidate_vld", 64'(candidate_vld), 64'(cv_e));
        for (int i = 0; i < N; i++) begin
            if (m_occ[i]) begin
                chk("candidate_key", 64'(candidate_key[i]), 64'(m_key[i]));
                chk("candidate_data", 64'(candidate_data[i]), 64'({IW'(i), m_data[i]}));
            end
        end
        if (pop_e) begin
            chk("pop_key", 64'(pop_key), 64'(w.key));
            chk("pop_data", 64'(pop_data), 64'(w.data[DW-1:0]));
        end
        pv_log.push_back(pop_vld);
        if (pop_vld && pr) begin
            pop_log.push_back({w.data[DW+IW-1 -: IW], pop_data});
            $display("pop  cycle=%0d tag=%0d key=%0d data=%h", cyc, tag, pop_key, pop_data);
        end
        if (pv && rdy_e) begin
            $display("push cycle=%0d slot=%0d key=%0d data=%h", cyc, fslot, pk, pd);
        end

        @(posedge clk);
        #1;

        if (cyc % P == P - 1) begin
            for (int i = 0; i < N; i++) begin
                if (m_occ[i] && !(pop_e && pr && tag == i) && m_key[i] != 6'h3F)
                    m_key[i] = m_key[i] + 1'b1;
            end
        end
        if (pop_e && pr) begin
            m_occ[tag] = 1'b0;
            m_free_at[tag] = cyc + L + 2;
        end
        if (pv && rdy_e) begin
            m_occ[fslot]  = 1'b1;
            m_key[fslot]  = pk;
            m_data[fslot] = pd;
        end
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] exp_pv;
        int k;

        // Reset state with a valid-looking winner presented.
        cyc = 0;
        #1 rst_n = 1'b0;
        winner_vld = 1'b1;
        winner_data = '0;
        #2;
        chk("reset_push_rdy", 64'(push_rdy), 64'd1);
        chk("reset_candidate_vld", 64'(candidate_vld), 64'd0);
        chk("reset_pop_vld", 64'(pop_vld), 64'd0);
        do_reset();

        // Keys 3,9,5 pop in order 9,5,3 with stale winners dropped in between.
        step(1'b1, 6'd3, 16'hA003, 1'b0);
        step(1'b1, 6'd9, 16'hA009, 1'b0);
        step(1'b1, 6'd5, 16'hA005, 1'b0);
        repeat (4) step(1'b0, '0, '0, 1'b0);
        pv_log.delete();
        pop_log.delete();
        repeat (12) step(1'b0, '0, '0, 1'b1);
        exp_pv = 12'b100_100_100_000;
        for (int i = 0; i < 12; i++) chk("t1_pop_vld_seq", 64'(pv_log[i]), 64'(exp_pv[11-i]));
        chk("t1_pop_count", 64'(pop_log.size()), 64'd3);
        if (pop_log.size() == 3) begin
            chk("t1_pop0", 64'(pop_log[0]), 64'({3'd1, 16'hA009}));
            chk("t1_pop1", 64'(pop_log[1]), 64'({3'd2, 16'hA005}));
            chk("t1_pop2", 64'(pop_log[2]), 64'({3'd0, 16'hA003}));
        end

        // Fill all slots; after one pop the slot is reusable only after L+2 cycles.
        repeat (5) step(1'b0, '0, '0, 1'b0);
        for (int i = 1; i <= 5; i++) step(1'b1, KW'(10 * i), DW'(16'hB000 + i), 1'b0);
        chk("t2_full_push_rdy", 64'(push_rdy), 64'd0);
        repeat (3) step(1'b0, '0, '0, 1'b0);
        step(1'b0, '0, '0, 1'b1);
        chk("t2_single_pop", 64'(pv_log[pv_log.size()-1]), 64'd1);
        k = 1;
        while (push_rdy == 1'b0 && k < 10) begin
            step(1'b0, '0, '0, 1'b0);
            k++;
        end
        chk("t2_cool_delay", 64'(k), 64'(L + 2));

        // Push and pop together with one free slot: push takes it, retiree cools.
        step(1'b1, 6'd7, 16'hC007, 1'b1);
        chk("t5_pop_fired", 64'(pv_log[pv_log.size()-1]), 64'd1);
        chk("t5_push_rdy", 64'(push_rdy), 64'd0);
        chk("t5_candidate_vld", 64'(candidate_vld), 64'(5'b10111));
        repeat (3) step(1'b0, '0, '0, 1'b0);

        // Aging: 60 saturates at 63, 0 reaches 3 after 12 cycles.
        do_reset();
        step(1'b1, 6'd60, 16'hD060, 1'b0);
        step(1'b1, 6'd0, 16'hD000, 1'b0);
        repeat (12) step(1'b0, '0, '0, 1'b0);
        chk("t4_key0_aged", 64'(candidate_key[1]), 64'd3);
        chk("t4_key60_sat", 64'(candidate_key[0]), 64'd63);
        chk("t4_model_key0", 64'(m_key[1]), 64'd3);
        repeat (8) step(1'b0, '0, '0, 1'b0);
        chk("t4_key60_hold", 64'(candidate_key[0]), 64'd63);

        // Reset mid-operation with 3 slots occupied and a held winner.
        step(1'b1, 6'd20, 16'hE020, 1'b0);
        repeat (3) step(1'b0, '0, '0, 1'b0);
        chk("t6_pre_reset_pop_vld", 64'(pop_vld), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_candidate_vld", 64'(candidate_vld), 64'd0);
        chk("t6_pop_vld", 64'(pop_vld), 64'd0);
        chk("t6_push_rdy", 64'(push_rdy), 64'd1);
        do_reset();

        // Randomized traffic, with occasional out-of-range tags.
        for (int n = 0; n < 1500; n++) begin
            bad_tag_inj = ($urandom_range(0, 39) == 0);
            step($urandom_range(0, 9) < 6, KW'($urandom), DW'($urandom), $urandom_range(0, 2) != 0);
        end
        bad_tag_inj = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
